// File: rtl/alu_serial16_pkg.sv
// Shared definitions for the bit-serial ALU.
// Holds the default operand width, the op-code constants seen on the op
// port and the FSM state encoding used by the top level.
package alu_serial16_pkg;

  localparam int unsigned WidthDefault = 16;

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b010;
  localparam logic [2:0] OpXor = 3'b011;
  localparam logic [2:0] OpAdd = 3'b100;
  localparam logic [2:0] OpSlt = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StFin  = 2'b10
  } state_e;

endpackage

// File: rtl/alu_serial16_alu1bit.sv
// One-bit ALU slice (Alu1bit), purely combinational.
// Ports:
//   a, b     operand bits
//   cin      carry in
//   binvert  invert b before use (subtract)
//   less     value returned for the SLT op code
//   op       operation code (AND, OR, XOR, ADD, SLT; others return 0)
//   result   slice result bit
//   cout     carry out of the full adder (valid for every op code)
module alu_serial16_alu1bit
  import alu_serial16_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       binvert,
  input  logic       less,
  input  logic [2:0] op,
  output logic       result,
  output logic       cout
);

  logic b_eff;
  logic sum;

  assign b_eff = b ^ binvert;
  assign sum   = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

  always_comb begin
    result = 1'b0;
    unique case (op)
      OpAnd:   result = a & b_eff;
      OpOr:    result = a | b_eff;
      OpXor:   result = a ^ b_eff;
      OpAdd:   result = sum;
      OpSlt:   result = less;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial16.sv
// Bit-serial ALU: one result bit per clock, LSB first, through a single
// one-bit slice. A start accepted in IDLE captures operands and controls;
// WIDTH RUN cycles follow, then one FIN cycle finalises result and flags
// and pulses done.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         request pulse, only sampled in IDLE
//   a, b          operands (captured on accepted start)
//   op, binvert   operation and subtract select (captured on accepted start)
//   busy          high from accepted start until done rises
//   done          one-cycle pulse, result and flags valid
//   result        final result, held until the next operation overwrites it
//   cout          carry out of MSB (ADD/SUB only)
//   zero          result equals zero
//   overflow      signed overflow (ADD/SUB only)
module alu_serial16
  import alu_serial16_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             binvert,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [2:0]       op_q;
  logic             binv_q;
  logic             carry_q;
  logic             cmsb_q;  // carry into the MSB, kept for overflow

  logic       is_slt;
  logic       is_add;
  logic       is_listed;
  logic [2:0] slice_op;
  logic       slice_binv;
  logic       slice_res;
  logic       slice_cout;

  // SLT runs the slice as a subtract; the less input is never used serially.
  assign is_slt     = (op_q == OpSlt);
  assign is_add     = (op_q == OpAdd);
  assign is_listed  = (op_q == OpAnd) || (op_q == OpOr) || (op_q == OpXor) || is_add || is_slt;
  assign slice_op   = is_slt ? OpAdd : op_q;
  assign slice_binv = binv_q | is_slt;

  alu_serial16_alu1bit u_alu1bit (
    .a       (a_sh_q[0]),
    .b       (b_sh_q[0]),
    .cin     (carry_q),
    .binvert (slice_binv),
    .less    (1'b0),
    .op      (slice_op),
    .result  (slice_res),
    .cout    (slice_cout)
  );

  // Finalisation values, consumed only in FIN.
  logic             ovf_raw;
  logic             slt_bit;
  logic [WIDTH-1:0] fin_result;

  assign ovf_raw = cmsb_q ^ carry_q;
  assign slt_bit = result[WIDTH-1] ^ ovf_raw;

  always_comb begin
    fin_result = '0;
    if (is_slt) begin
      fin_result[0] = slt_bit;
    end else if (is_listed) begin
      fin_result = result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      op_q     <= OpAnd;
      binv_q   <= 1'b0;
      carry_q  <= 1'b0;
      cmsb_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            op_q    <= op;
            binv_q  <= binvert;
            cnt_q   <= '0;
            carry_q <= binvert | (op == OpSlt);
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          carry_q <= slice_cout;
          // Shift in from the MSB end so bit 0 ends up at result[0].
          result  <= {slice_res, result[WIDTH-1:1]};
          if (cnt_q == CntLast) begin
            cmsb_q  <= carry_q;
            state_q <= StFin;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFin: begin
          result   <= fin_result;
          zero     <= is_listed & (fin_result == '0);
          cout     <= is_add & carry_q;
          overflow <= is_add & ovf_raw;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial16.sv
// Directed bench for alu_serial16 with hand-computed expected values.
module tb_alu_serial16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  op;
  logic        binvert;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        zero;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cycles;

  alu_serial16 #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .op       (op),
    .binvert  (binvert),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .zero     (zero),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive a request; caller is positioned away from a rising edge.
  task automatic launch(input logic [15:0] ta, input logic [15:0] tb_, input logic [2:0] top,
                        input logic tbinv);
    a       = ta;
    b       = tb_;
    op      = top;
    binvert = tbinv;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count rising edges after the accepting edge until done is seen.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] r, input logic c,
                           input logic z, input logic v);
    check_eq({tag, ".result"}, 32'(result), 32'(r));
    check_eq({tag, ".cout"}, 32'(cout), 32'(c));
    check_eq({tag, ".zero"}, 32'(zero), 32'(z));
    check_eq({tag, ".overflow"}, 32'(overflow), 32'(v));
    check_eq({tag, ".busy"}, 32'(busy), 32'(0));
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic [2:0] top, input logic tbinv, input logic [15:0] r,
                        input logic c, input logic z, input logic v);
    @(negedge clk);
    launch(ta, tb_, top, tbinv);
    check_eq({tag, ".busy_after_start"}, 32'(busy), 32'(1));
    wait_done(cycles);
    check_eq({tag, ".latency"}, 32'(cycles), 32'(17));
    check_out(tag, r, c, z, v);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    op      = 3'b000;
    binvert = 1'b0;
    #12;
    check_eq("reset.busy", 32'(busy), 32'(0));
    check_eq("reset.done", 32'(done), 32'(0));
    check_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ovf", 16'h7FFF, 16'h0001, 3'b100, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
    run_op("sub_eq", 16'h1234, 16'h1234, 3'b100, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 3'b100, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 3'b100, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1);
    run_op("slt_lt", 16'hFFFF, 16'h0001, 3'b111, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("slt_ge", 16'h0001, 16'hFFFF, 3'b111, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op("or", 16'hF0F0, 16'h0FF0, 3'b010, 1'b0, 16'hFFF0, 1'b0, 1'b0, 1'b0);
    run_op("unlisted", 16'h1234, 16'h5678, 3'b101, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // AND, then XOR requested in the done cycle.
    run_op("and", 16'hF0F0, 16'h0FF0, 3'b000, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0);
    launch(16'hF0F0, 16'h0FF0, 3'b011, 1'b0);
    check_eq("b2b.busy_after_start", 32'(busy), 32'(1));
    check_eq("b2b.done_dropped", 32'(done), 32'(0));
    wait_done(cycles);
    check_eq("b2b.latency", 32'(cycles), 32'(17));
    check_out("xor_b2b", 16'hFF00, 1'b0, 1'b0, 1'b0);

    // Start pulsed at bit 5 with new operands must be ignored.
    @(negedge clk);
    launch(16'h1111, 16'h2222, 3'b100, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    launch(16'hFFFF, 16'hFFFF, 3'b010, 1'b1);
    a = 16'hAAAA;
    b = 16'h5555;
    wait_done(cycles);
    check_eq("ignore.latency", 32'(cycles + 5), 32'(17));
    check_out("ignore", 16'h3333, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("ignore.no_restart", 32'(busy), 32'(0));

    // Reset at bit 8 of a running op.
    @(negedge clk);
    launch(16'h7FFF, 16'h0001, 3'b100, 1'b0);
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("abort.done", 32'(done), 32'(0));
    check_out("abort", 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_eq("abort.no_done", 32'(done), 32'(0));
    check_eq("abort.idle", 32'(busy), 32'(0));
    run_op("add_after_rst", 16'h0001, 16'h0001, 3'b100, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
